// File: rtl/rf_pkg.sv
// Shared widths and the writeback-source encoding for the register-file
// writeback scheduler and its scoreboard.
package rf_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    // Which source owns the registered write-port slot this cycle.
    typedef enum logic [1:0] {
        WB_NONE,
        WB_PIPE,
        WB_LU
    } wb_src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for registers with a long-latency (LU) write in flight.
// Issue of an LU instruction marks its destination busy; the LU writeback
// clears it. Stall is computed from the registered busy bits only.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rs1,
    input  logic [REG_AW-1:0] issue_rs2,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              issue_uses_lu,
    input  logic              lu_fire,
    input  logic [REG_AW-1:0] lu_rd,
    output logic              issue_stall,
    output logic [NREG-1:0]   busy_mask
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            rs1_hit;
    logic            rs2_hit;
    logic            rd_hit;
    logic            issue_fire;

    // Hazard compare against registered busy; x0 never hazards.
    always_comb begin
        rs1_hit     = (issue_rs1 != '0) && busy_q[issue_rs1];
        rs2_hit     = (issue_rs2 != '0) && busy_q[issue_rs2];
        rd_hit      = (issue_rd  != '0) && busy_q[issue_rd];
        issue_stall = issue_valid && (rs1_hit || rs2_hit || rd_hit);
        issue_fire  = issue_valid && !issue_stall;
    end

    // Clear first, then set, so a same-cycle set on the same bit wins.
    always_comb begin
        busy_d = busy_q;
        if (lu_fire) begin
            busy_d[lu_rd] = 1'b0;
        end
        if (issue_fire && issue_uses_lu && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy register, cleared asynchronously so in-flight LU ops are forgotten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_mask = busy_q;

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file writeback scheduler: arbitrates the single RF write port
// between the main pipeline and a long-latency unit (pipe has priority, LU
// gets a forced grant after STARVE_LIMIT waiting cycles), registers the
// write port, and hosts the issue-side scoreboard.
module rf_wb_scheduler
    import rf_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_valid,
    input  logic [REG_AW-1:0] pipe_rd,
    input  logic [XLEN-1:0]   pipe_data,
    output logic              pipe_ready,
    input  logic              lu_valid,
    input  logic [REG_AW-1:0] lu_rd,
    input  logic [XLEN-1:0]   lu_data,
    output logic              lu_ready,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rs1,
    input  logic [REG_AW-1:0] issue_rs2,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              issue_uses_lu,
    output logic              issue_stall,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic [NREG-1:0]   busy_mask
);

    // Counter must be able to hold STARVE_LIMIT itself.
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]  starve_cnt_q;
    logic [CNT_W-1:0]  starve_cnt_d;
    logic              starve_hit;
    logic              pipe_fire;
    logic              lu_fire;
    wb_src_e           wb_src_q;
    wb_src_e           wb_src_d;
    logic [REG_AW-1:0] waddr_q;
    logic [REG_AW-1:0] waddr_d;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   wdata_d;

    // Fixed-priority grant with starvation override; at most one fire.
    always_comb begin
        starve_hit = lu_valid && (starve_cnt_q == STARVE_MAX);
        lu_ready   = lu_valid && (!pipe_valid || starve_hit);
        pipe_ready = !starve_hit;
        pipe_fire  = pipe_valid && pipe_ready;
        lu_fire    = lu_valid && lu_ready;
    end

    // Starvation counter: count LU waiting cycles, saturate, clear on fire or idle.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!lu_valid || lu_fire) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Next write-port contents; fires to x0 complete but commit nothing.
    always_comb begin
        wb_src_d = WB_NONE;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        if (lu_fire && (lu_rd != '0)) begin
            wb_src_d = WB_LU;
            waddr_d  = lu_rd;
            wdata_d  = lu_data;
        end else if (pipe_fire && (pipe_rd != '0)) begin
            wb_src_d = WB_PIPE;
            waddr_d  = pipe_rd;
            wdata_d  = pipe_data;
        end
    end

    // Write-port and counter registers; async reset drops any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
            wb_src_q     <= WB_NONE;
            waddr_q      <= '0;
            wdata_q      <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            wb_src_q     <= wb_src_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign rf_we    = (wb_src_q != WB_NONE);
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;

    rf_scoreboard u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_rd      (issue_rd),
        .issue_uses_lu (issue_uses_lu),
        .lu_fire       (lu_fire),
        .lu_rd         (lu_rd),
        .issue_stall   (issue_stall),
        .busy_mask     (busy_mask)
    );

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed testbench for rf_wb_scheduler.
module tb_rf_wb_scheduler;

    logic        clk;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_ready;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        issue_uses_lu;
    logic        issue_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy_mask;

    int total;
    int bad;

    rf_wb_scheduler #(.STARVE_LIMIT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_valid    (pipe_valid),
        .pipe_rd       (pipe_rd),
        .pipe_data     (pipe_data),
        .pipe_ready    (pipe_ready),
        .lu_valid      (lu_valid),
        .lu_rd         (lu_rd),
        .lu_data       (lu_data),
        .lu_ready      (lu_ready),
        .issue_valid   (issue_valid),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_rd      (issue_rd),
        .issue_uses_lu (issue_uses_lu),
        .issue_stall   (issue_stall),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .busy_mask     (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
        lu_valid = 0; lu_rd = 0; lu_data = 0;
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_uses_lu = 0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", rf_we); end
        total++; if (rf_waddr !== 5'd0) begin bad++; $display("FAIL rst_waddr: got %0d want 0", rf_waddr); end
        total++; if (rf_wdata !== 32'd0) begin bad++; $display("FAIL rst_wdata: got %h want 0", rf_wdata); end
        total++; if (busy_mask !== 32'd0) begin bad++; $display("FAIL rst_busy: got %h want 0", busy_mask); end
        total++; if (pipe_ready !== 1'b1) begin bad++; $display("FAIL rst_pipe_ready: got %b want 1", pipe_ready); end
        total++; if (lu_ready !== 1'b0) begin bad++; $display("FAIL rst_lu_ready_idle: got %b want 0", lu_ready); end
        lu_valid = 1; #1;
        total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL rst_lu_ready_alone: got %b want 1", lu_ready); end
        pipe_valid = 1; #1;
        total++; if (lu_ready !== 1'b0) begin bad++; $display("FAIL rst_lu_ready_both: got %b want 0", lu_ready); end
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rst_we_held: got %b want 0", rf_we); end
        idle_inputs();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_pipe();
        pipe_valid = 1; pipe_rd = 5; pipe_data = 32'hDEADBEEF;
        #1;
        total++; if (pipe_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", pipe_ready); end
        step();
        pipe_valid = 0;
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL single_we: got %b want 1", rf_we); end
        total++; if (rf_waddr !== 5'd5) begin bad++; $display("FAIL single_waddr: got %0d want 5", rf_waddr); end
        total++; if (rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wdata: got %h want deadbeef", rf_wdata); end
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL single_we_drop: got %b want 0", rf_we); end
    endtask

    task automatic test_starvation();
        logic [31:0] exp_d;
        lu_valid = 1; lu_rd = 12; lu_data = 32'h0000CAFE;
        pipe_valid = 1; pipe_rd = 3;
        for (int c = 0; c < 5; c++) begin
            pipe_data = 32'h100 + c;
            #1;
            total++; if (lu_ready !== (c == 4)) begin bad++; $display("FAIL starve_lu_ready_c%0d: got %b want %b", c, lu_ready, (c == 4)); end
            total++; if (pipe_ready !== (c != 4)) begin bad++; $display("FAIL starve_pipe_ready_c%0d: got %b want %b", c, pipe_ready, (c != 4)); end
            if (c >= 1) begin
                exp_d = 32'h100 + c - 1;
                total++; if (rf_waddr !== 5'd3 || rf_wdata !== exp_d) begin bad++; $display("FAIL starve_wb_c%0d: got %0d/%h want 3/%h", c, rf_waddr, rf_wdata, exp_d); end
            end
            step();
        end
        lu_valid = 0;
        #1;
        total++; if (pipe_ready !== 1'b1) begin bad++; $display("FAIL starve_resume: got %b want 1", pipe_ready); end
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'h0000CAFE) begin bad++; $display("FAIL starve_lu_wb: got %b/%0d/%h want 1/12/0000cafe", rf_we, rf_waddr, rf_wdata); end
        step();
        pipe_valid = 0;
        total++; if (rf_waddr !== 5'd3 || rf_wdata !== 32'h104) begin bad++; $display("FAIL starve_pipe_after: got %0d/%h want 3/104", rf_waddr, rf_wdata); end
        step();
    endtask

    task automatic test_scoreboard();
        issue_valid = 1; issue_rd = 7; issue_uses_lu = 1;
        #1;
        total++; if (issue_stall !== 1'b0) begin bad++; $display("FAIL sb_first_issue: got %b want 0", issue_stall); end
        step();
        issue_valid = 0; issue_uses_lu = 0; issue_rd = 0;
        total++; if (busy_mask !== 32'h80) begin bad++; $display("FAIL sb_set: got %h want 80", busy_mask); end
        issue_valid = 1; issue_rs2 = 7; #1;
        total++; if (issue_stall !== 1'b1) begin bad++; $display("FAIL sb_rs2_stall: got %b want 1", issue_stall); end
        issue_rs2 = 0; issue_rd = 7; #1;
        total++; if (issue_stall !== 1'b1) begin bad++; $display("FAIL sb_rd_stall: got %b want 1", issue_stall); end
        issue_valid = 0; #1;
        total++; if (issue_stall !== 1'b0) begin bad++; $display("FAIL sb_no_valid: got %b want 0", issue_stall); end
        // Reader of x7 stalls; a pipe write to x7 must not clear busy.
        issue_valid = 1; issue_rs1 = 7; issue_rd = 8; issue_uses_lu = 0;
        pipe_valid = 1; pipe_rd = 7; pipe_data = 32'h77;
        #1;
        total++; if (issue_stall !== 1'b1) begin bad++; $display("FAIL sb_rs1_stall: got %b want 1", issue_stall); end
        step();
        pipe_valid = 0;
        total++; if (busy_mask !== 32'h80) begin bad++; $display("FAIL sb_pipe_no_clear: got %h want 80", busy_mask); end
        lu_valid = 1; lu_rd = 7; lu_data = 32'h1234;
        #1;
        total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL sb_lu_ready: got %b want 1", lu_ready); end
        total++; if (issue_stall !== 1'b1) begin bad++; $display("FAIL sb_stall_same_cycle: got %b want 1", issue_stall); end
        step();
        lu_valid = 0;
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL sb_clear: got %h want 0", busy_mask); end
        total++; if (issue_stall !== 1'b0) begin bad++; $display("FAIL sb_stall_release: got %b want 0", issue_stall); end
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h1234) begin bad++; $display("FAIL sb_lu_wb: got %b/%0d/%h want 1/7/1234", rf_we, rf_waddr, rf_wdata); end
        step();
        issue_valid = 0; issue_rs1 = 0; issue_rd = 0;
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL sb_nonlu_issue: got %h want 0", busy_mask); end
    endtask

    task automatic test_simultaneous();
        lu_valid = 1; lu_rd = 9; lu_data = 32'h99;
        issue_valid = 1; issue_rd = 9; issue_uses_lu = 1;
        #1;
        total++; if (lu_ready !== 1'b1 || issue_stall !== 1'b0) begin bad++; $display("FAIL simul_fire: got lu_ready=%b stall=%b want 1/0", lu_ready, issue_stall); end
        step();
        lu_valid = 0; issue_valid = 0; issue_uses_lu = 0; issue_rd = 0;
        total++; if (busy_mask !== 32'h200) begin bad++; $display("FAIL simul_set_wins: got %h want 200", busy_mask); end
        lu_valid = 1;
        step();
        lu_valid = 0;
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL simul_later_clear: got %h want 0", busy_mask); end
    endtask

    task automatic test_x0();
        lu_valid = 1; lu_rd = 0; lu_data = 32'h5555;
        #1;
        total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL x0_lu_ready: got %b want 1", lu_ready); end
        step();
        lu_valid = 0;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL x0_lu_we: got %b want 0", rf_we); end
        pipe_valid = 1; pipe_rd = 0; pipe_data = 32'h6666;
        #1;
        total++; if (pipe_ready !== 1'b1) begin bad++; $display("FAIL x0_pipe_ready: got %b want 1", pipe_ready); end
        step();
        pipe_valid = 0;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL x0_pipe_we: got %b want 0", rf_we); end
        issue_valid = 1; issue_rd = 0; issue_uses_lu = 1;
        step();
        issue_valid = 0; issue_uses_lu = 0;
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL x0_busy: got %h want 0", busy_mask); end
    endtask

    task automatic test_mid_reset();
        issue_valid = 1; issue_uses_lu = 1; issue_rd = 4;
        step();
        issue_rd = 5;
        step();
        issue_valid = 0; issue_uses_lu = 0; issue_rd = 0;
        pipe_valid = 1; pipe_rd = 10; pipe_data = 32'hA5A5A5A5;
        step();
        pipe_valid = 0;
        total++; if (rf_we !== 1'b1 || busy_mask !== 32'h30) begin bad++; $display("FAIL mid_pre: got we=%b busy=%h want 1/30", rf_we, busy_mask); end
        rst = 1'b1;
        #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL mid_we: got %b want 0", rf_we); end
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL mid_busy: got %h want 0", busy_mask); end
        total++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin bad++; $display("FAIL mid_port: got %0d/%h want 0/0", rf_waddr, rf_wdata); end
        #1 rst = 1'b0;
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL mid_no_commit: got %b want 0", rf_we); end
    endtask

    task automatic test_starve_reset();
        pipe_valid = 1; pipe_rd = 2; pipe_data = 32'h22;
        lu_valid = 1; lu_rd = 6; lu_data = 32'h66;
        for (int c = 0; c < 4; c++) step();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        total++; if (lu_ready !== 1'b0 || pipe_ready !== 1'b1) begin bad++; $display("FAIL starve_cnt_reset: got lu=%b pipe=%b want 0/1", lu_ready, pipe_ready); end
        idle_inputs();
        step();
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_single_pipe();
        test_starvation();
        test_scoreboard();
        test_simultaneous();
        test_x0();
        test_mid_reset();
        test_starve_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop so the bench can never hang.
    initial begin
        #20000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule

// File: doc/rf_wb_scheduler.md
RF_WB_SCHEDULER -- requirements
Module: rf_wb_scheduler

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive cycles the long-latency unit (LU) may wait before a forced grant.
REQ-002 SHALL have ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
REQ-003 SHALL have pipeline writeback ports:
- pipe_valid, in, 1: pipeline write request.
- pipe_rd, in, 5: destination register.
- pipe_data, in, 32: write data.
- pipe_ready, out, 1: grant.
REQ-004 SHALL have LU writeback ports:
- lu_valid, in, 1: LU write request.
- lu_rd, in, 5: destination register.
- lu_data, in, 32: write data.
- lu_ready, out, 1: grant.
REQ-005 SHALL have issue-side ports:
- issue_valid, in, 1: instruction at issue.
- issue_rs1, in, 5; issue_rs2, in, 5; issue_rd, in, 5: operand and destination registers.
- issue_uses_lu, in, 1: instruction completes through LU.
- issue_stall, out, 1: hazard, hold issue.
REQ-006 SHALL have register-file write-port outputs:
- rf_we, out, 1.
- rf_waddr, out, 5.
- rf_wdata, out, 32.
REQ-007 SHALL have status output busy_mask, out, 32: scoreboard contents.

Function
REQ-008 A handshake SHALL fire when valid && ready in the same cycle; valid and payload SHALL be held stable by the source until fire.
REQ-009 Arbitration SHALL be fixed-priority, pipe over LU: lu_ready = lu_valid && (!pipe_valid || starve_cnt == STARVE_LIMIT); pipe_ready = !(lu_valid && starve_cnt == STARVE_LIMIT).
REQ-010 At most one source SHALL fire per cycle.
REQ-011 starve_cnt SHALL increment, saturating at STARVE_LIMIT, each cycle with lu_valid && !lu_ready; it SHALL clear on LU fire or when lu_valid is low.
REQ-012 The write port SHALL be registered, latency 1: a fire in cycle N drives rf_we=1, rf_waddr=rd and rf_wdata=data in cycle N+1.
REQ-013 rf_we SHALL be 0 in any cycle following one with no fire.
REQ-014 A fire with rd==0 SHALL complete the handshake but SHALL leave rf_we=0.
REQ-015 The scoreboard busy[31:0] SHALL keep busy[0] constant 0; busy_mask = busy.
REQ-016 issue_stall SHALL be asserted combinationally when issue_valid is high and any nonzero register among issue_rs1, issue_rs2, issue_rd has its busy bit set.
REQ-017 issue_stall SHALL be evaluated from registered busy only: a clear in the same cycle does not release the stall until the next cycle.
REQ-018 Issue fire = issue_valid && !issue_stall; if issue_uses_lu is set and issue_rd != 0, busy[issue_rd] SHALL be set on the next edge.
REQ-019 An LU fire SHALL clear busy[lu_rd] on the next edge.
REQ-020 A set and a clear of the same bit in the same cycle SHALL leave the bit set.
REQ-021 A pipe fire SHALL never modify busy.

Reset
REQ-022 During rst, the following SHALL be 0 immediately, independent of clk: rf_we, rf_waddr, rf_wdata, busy, starve_cnt.
REQ-023 Reset mid-operation SHALL drop any registered write without committing it; pending LU ops SHALL be forgotten.
REQ-024 pipe_ready and lu_ready SHALL follow REQ-009 combinationally during reset.

Structure
REQ-025 Package rf_pkg SHALL hold XLEN=32, NREG=32, REG_AW=5, and enum wb_src_e {WB_NONE, WB_PIPE, WB_LU}, the latter used internally for the registered grant.
REQ-026 The scoreboard (busy register, set/clear logic, stall compare) SHALL be sub-module rf_scoreboard; arbitration, starvation counter and write-port register stay in rf_wb_scheduler.

Verification
REQ-027 Single-source timing: pipe_valid=1, rd=5, data=0xDEADBEEF, lu_valid=0 -> pipe_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-028 Starvation: pipe_valid=1 continuously with lu_valid=1 -> lu_ready=0 for cycles 0..3, lu_ready=1 and pipe_ready=0 on cycle 4, then pipe resumes.
REQ-029 Scoreboard set/clear: issue rd=7 with issue_uses_lu=1 -> busy_mask=0x80; an issue reading rs1=7 stalls; LU fire rd=7 -> busy_mask=0 and stall drops one cycle later.
REQ-030 Simultaneous set/clear: LU fire lu_rd=9 in the same cycle as issue fire rd=9 with issue_uses_lu=1 -> busy[9] remains 1.
REQ-031 x0 handling: LU fire with lu_rd=0 -> lu_ready=1, rf_we stays 0; an issue with issue_uses_lu=1 and rd=0 -> busy_mask stays 0.
REQ-032 Mid-operation reset: rst asserted while rf_we=1 and busy_mask=0x30 -> rf_we=0 and busy_mask=0 immediately, before the next clk edge.
